// File: rtl/writeback_regfile_if.sv
// MEM/WB writeback and ID-stage read-port bundle for the register file.
// Purely combinational signalling; no handshake, the pipeline never stalls this stage.
interface writeback_regfile_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_Ctrl_Jal;
  logic                  in_Ctrl_RegWrite;
  logic                  in_Ctrl_MemToReg;
  logic [DATA_WIDTH-1:0] in_RAM_Read_Data;
  logic [DATA_WIDTH-1:0] in_ALU_Result;
  logic [4:0]            in_Write_Register;
  logic [DATA_WIDTH-1:0] in_Return_Address;
  logic [4:0]            in_Read_Register_1;
  logic [4:0]            in_Read_Register_2;
  logic [DATA_WIDTH-1:0] out_Read_Data_1;
  logic [DATA_WIDTH-1:0] out_Read_Data_2;
  logic [DATA_WIDTH-1:0] out_WB_Data;
  logic [DATA_WIDTH-1:0] out_Write_Count;

  modport master (
    output in_Ctrl_Jal, in_Ctrl_RegWrite, in_Ctrl_MemToReg,
    output in_RAM_Read_Data, in_ALU_Result, in_Write_Register, in_Return_Address,
    output in_Read_Register_1, in_Read_Register_2,
    input  out_Read_Data_1, out_Read_Data_2, out_WB_Data, out_Write_Count
  );

  modport slave (
    input  in_Ctrl_Jal, in_Ctrl_RegWrite, in_Ctrl_MemToReg,
    input  in_RAM_Read_Data, in_ALU_Result, in_Write_Register, in_Return_Address,
    input  in_Read_Register_1, in_Read_Register_2,
    output out_Read_Data_1, out_Read_Data_2, out_WB_Data, out_Write_Count
  );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback select + 32-entry register file with write-to-read bypass and a wrapping commit counter.
// Reads are combinational (same-cycle bypass), writes land on the rising edge; never backpressures.
module writeback_regfile #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [4:0] RA_INDEX   = 5'd31
) (
  input logic                clk,
  input logic                reset,
  writeback_regfile_if.slave bus
);

  logic [DATA_WIDTH-1:0] regs [32];
  logic [DATA_WIDTH-1:0] write_count;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [4:0]            wa;
  logic                  we;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rd_data_1;
  logic [DATA_WIDTH-1:0] rd_data_2;

  // jal overrides both the destination and the data source, even with RegWrite low
  always_comb begin
    wa      = bus.in_Ctrl_Jal ? RA_INDEX : bus.in_Write_Register;
    we      = bus.in_Ctrl_Jal | bus.in_Ctrl_RegWrite;
    commit  = we && (wa != 5'd0);
    wb_data = bus.in_ALU_Result;
    if (bus.in_Ctrl_Jal)
      wb_data = bus.in_Return_Address;
    else if (bus.in_Ctrl_MemToReg)
      wb_data = bus.in_RAM_Read_Data;
  end

  always_comb begin
    rd_data_1 = regs[bus.in_Read_Register_1];
    if (bus.in_Read_Register_1 == 5'd0)
      rd_data_1 = '0;
    else if (commit && (bus.in_Read_Register_1 == wa))
      rd_data_1 = wb_data;
  end

  always_comb begin
    rd_data_2 = regs[bus.in_Read_Register_2];
    if (bus.in_Read_Register_2 == 5'd0)
      rd_data_2 = '0;
    else if (commit && (bus.in_Read_Register_2 == wa))
      rd_data_2 = wb_data;
  end

  // Entry 0 is cleared by reset and never written, so it stays zero in the array too
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        regs[i] <= '0;
      write_count <= '0;
    end else if (commit) begin
      regs[wa]    <= wb_data;
      write_count <= write_count + 1'b1;
    end
  end

  assign bus.out_Read_Data_1 = rd_data_1;
  assign bus.out_Read_Data_2 = rd_data_2;
  assign bus.out_WB_Data     = wb_data;
  assign bus.out_Write_Count = write_count;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed-vector bench for writeback_regfile; a narrow second instance exercises counter wrap.
module tb_writeback_regfile;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  writeback_regfile_if #(.DATA_WIDTH(32)) m_bus ();
  writeback_regfile_if #(.DATA_WIDTH(4))  s_bus ();

  writeback_regfile #(.DATA_WIDTH(32), .RA_INDEX(5'd31)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (m_bus)
  );

  writeback_regfile #(.DATA_WIDTH(4), .RA_INDEX(5'd31)) dut_narrow (
    .clk   (clk),
    .reset (reset),
    .bus   (s_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic jal, input logic rw, input logic m2r,
                       input logic [31:0] ram, input logic [31:0] alu,
                       input logic [4:0] wr, input logic [31:0] ret);
    m_bus.in_Ctrl_Jal       = jal;
    m_bus.in_Ctrl_RegWrite  = rw;
    m_bus.in_Ctrl_MemToReg  = m2r;
    m_bus.in_RAM_Read_Data  = ram;
    m_bus.in_ALU_Result     = alu;
    m_bus.in_Write_Register = wr;
    m_bus.in_Return_Address = ret;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h0);
  endtask

  task automatic rd(input logic [4:0] r1, input logic [4:0] r2);
    m_bus.in_Read_Register_1 = r1;
    m_bus.in_Read_Register_2 = r2;
    #1;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    reset   = 1'b1;
    idle();
    rd(5'd0, 5'd0);
    s_bus.in_Ctrl_Jal        = 1'b0;
    s_bus.in_Ctrl_RegWrite   = 1'b0;
    s_bus.in_Ctrl_MemToReg   = 1'b0;
    s_bus.in_RAM_Read_Data   = 4'h0;
    s_bus.in_ALU_Result      = 4'h0;
    s_bus.in_Write_Register  = 5'd0;
    s_bus.in_Return_Address  = 4'h0;
    s_bus.in_Read_Register_1 = 5'd1;
    s_bus.in_Read_Register_2 = 5'd2;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    rd(5'd5, 5'd31);
    check_val("rst_r5", m_bus.out_Read_Data_1, 32'h0);
    check_val("rst_r31", m_bus.out_Read_Data_2, 32'h0);
    check_val("rst_count", m_bus.out_Write_Count, 32'h0);

    // Write r5 then reset clears it
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5, 32'h0);
    tick();
    idle();
    rd(5'd5, 5'd0);
    check_val("r5_written", m_bus.out_Read_Data_1, 32'hDEADBEEF);
    check_val("count_1", m_bus.out_Write_Count, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(5'd5, 5'd0);
    check_val("r5_after_rst", m_bus.out_Read_Data_1, 32'h0);
    check_val("count_after_rst", m_bus.out_Write_Count, 32'h0);

    // Reset wins over a simultaneous commit, but bypass is still visible
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h00000077, 5'd6, 32'h0);
    rd(5'd6, 5'd0);
    check_val("rst_bypass", m_bus.out_Read_Data_1, 32'h00000077);
    tick();
    reset = 1'b0;
    idle();
    rd(5'd6, 5'd0);
    check_val("rst_drop_r6", m_bus.out_Read_Data_1, 32'h0);
    check_val("rst_drop_count", m_bus.out_Write_Count, 32'h0);

    // ALU then memory select
    drive(1'b0, 1'b1, 1'b0, 32'h00000BAD, 32'h00000011, 5'd8, 32'h0);
    rd(5'd0, 5'd0);
    check_val("wb_alu", m_bus.out_WB_Data, 32'h00000011);
    tick();
    idle();
    rd(5'd8, 5'd0);
    check_val("r8_alu", m_bus.out_Read_Data_1, 32'h00000011);
    drive(1'b0, 1'b1, 1'b1, 32'h12345678, 32'h00000022, 5'd8, 32'h0);
    rd(5'd0, 5'd0);
    check_val("wb_mem", m_bus.out_WB_Data, 32'h12345678);
    tick();
    idle();
    rd(5'd0, 5'd8);
    check_val("r8_mem", m_bus.out_Read_Data_2, 32'h12345678);
    check_val("count_2", m_bus.out_Write_Count, 32'd2);

    // jal: RegWrite low, MemToReg high, destination field ignored
    drive(1'b1, 1'b0, 1'b1, 32'h0000AAAA, 32'h0000BBBB, 5'd8, 32'h00400024);
    rd(5'd0, 5'd0);
    check_val("wb_jal", m_bus.out_WB_Data, 32'h00400024);
    tick();
    idle();
    rd(5'd31, 5'd8);
    check_val("r31_jal", m_bus.out_Read_Data_1, 32'h00400024);
    check_val("r8_kept", m_bus.out_Read_Data_2, 32'h12345678);
    check_val("count_3", m_bus.out_Write_Count, 32'd3);

    // Writes to r0 are discarded, not bypassed, not counted
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 32'h0);
    rd(5'd0, 5'd0);
    check_val("r0_no_bypass", m_bus.out_Read_Data_1, 32'h0);
    tick();
    idle();
    rd(5'd0, 5'd0);
    check_val("r0_stored", m_bus.out_Read_Data_2, 32'h0);
    check_val("count_r0", m_bus.out_Write_Count, 32'd3);

    // Bypass on both ports, and no bypass without RegWrite
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h00000099, 5'd9, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'hA5A5A5A5, 5'd9, 32'h0);
    rd(5'd9, 5'd9);
    check_val("nobyp_p1", m_bus.out_Read_Data_1, 32'h00000099);
    check_val("nobyp_p2", m_bus.out_Read_Data_2, 32'h00000099);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'hA5A5A5A5, 5'd9, 32'h0);
    rd(5'd9, 5'd9);
    check_val("byp_p1", m_bus.out_Read_Data_1, 32'hA5A5A5A5);
    check_val("byp_p2", m_bus.out_Read_Data_2, 32'hA5A5A5A5);
    tick();
    idle();
    rd(5'd9, 5'd31);
    check_val("r9_stored", m_bus.out_Read_Data_1, 32'hA5A5A5A5);
    check_val("r31_port2", m_bus.out_Read_Data_2, 32'h00400024);
    check_val("count_5", m_bus.out_Write_Count, 32'd5);

    // jal bypass to r31 on one port while the other reads an unrelated register
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 32'h00400100);
    rd(5'd31, 5'd8);
    check_val("jal_byp_r31", m_bus.out_Read_Data_1, 32'h00400100);
    check_val("jal_byp_r8", m_bus.out_Read_Data_2, 32'h12345678);
    tick();
    idle();
    check_val("count_6", m_bus.out_Write_Count, 32'd6);

    // Narrow instance: 15 commits reach the top value, the 16th wraps to 0
    s_bus.in_Ctrl_RegWrite  = 1'b1;
    s_bus.in_Write_Register = 5'd1;
    for (int i = 0; i < 15; i++) begin
      s_bus.in_ALU_Result = 4'(i);
      tick();
    end
    check_val("narrow_count_max", {28'h0, s_bus.out_Write_Count}, 32'h0000000F);
    s_bus.in_ALU_Result = 4'hC;
    tick();
    s_bus.in_Ctrl_RegWrite = 1'b0;
    #1;
    check_val("narrow_count_wrap", {28'h0, s_bus.out_Write_Count}, 32'h0);
    check_val("narrow_r1", {28'h0, s_bus.out_Read_Data_1}, 32'h0000000C);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
